// File: rtl/u_ofmap_writer.sv
// Output-feature-map writer: bias add, round/shift/saturate to int8, 4-byte packing, FIFO, SRAM write port.
// Define OFMAP_RELU_EN to clamp negative quantized bytes to zero (fused ReLU).
module u_ofmap_writer #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk_cal,
  input  logic               rst_cal_n,
  input  logic               Start,
  input  logic [ADDR_W-1:0]  BaseAddr,
  input  logic [CNT_W-1:0]   OutCount,
  input  logic signed [15:0] Bias,
  input  logic [3:0]         Shift,
  input  logic signed [15:0] IOMap,
  input  logic               IOMapVld,
  input  logic               IWrReady,
  output logic               OWrEn,
  output logic [ADDR_W-1:0]  OWrAddr,
  output logic [31:0]        OWrData,
  output logic [3:0]         OWrStrb,
  output logic               OBusy,
  output logic               ODone,
  output logic               OOvf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state, stateNext;
  logic [CNT_W-1:0]    outCount;
  logic signed [15:0]  bias;
  logic [3:0]          shift;
  logic [CNT_W-1:0]    accCnt;
  logic                acc;
  logic                vld_p0;
  logic                last_p0;
  logic signed [7:0]   qByte_p0;
  logic [1:0]          laneCnt;
  logic [31:0]         packBuf;
  logic [31:0]         packData;
  logic [3:0]          packStrb;
  logic                push;
  logic                pop;
  logic                full;
  logic                wrOk;
  logic                lastPushed;
  logic [PTR_W:0]      fifoCnt;
  logic [PTR_W-1:0]    wrPtr, rdPtr;
  logic [31:0]         memData [FIFO_DEPTH];
  logic [3:0]          memStrb [FIFO_DEPTH];

  // Bias add in 18 bits, add half an LSB of the shifted result, then arithmetic shift (round half up).
  function automatic logic signed [17:0] roundShift(input logic signed [15:0] x,
                                                     input logic signed [15:0] b,
                                                     input logic [3:0]         sh);
    logic signed [17:0] s;
    logic signed [17:0] rnd;
    s   = $signed({{2{x[15]}}, x}) + $signed({{2{b[15]}}, b});
    rnd = (sh == 4'd0) ? 18'sd0 : (18'sd1 <<< (sh - 4'd1));
    return (s + rnd) >>> sh;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [17:0] r);
    logic signed [7:0] q;
    if (r > 18'sd127)       q = 8'sd127;
    else if (r < -18'sd128) q = -8'sd128;
    else                    q = r[7:0];
`ifdef OFMAP_RELU_EN
    if (q[7]) q = '0;
`endif
    return q;
  endfunction

  assign acc  = IOMapVld && (state == RUN) && (accCnt < outCount) && !Start;
  assign pop  = OWrEn && IWrReady;
  assign full = (fifoCnt == (PTR_W+1)'(FIFO_DEPTH));
  assign wrOk = push && (!full || pop);

  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) begin
      outCount <= '0;
      bias     <= '0;
      shift    <= '0;
      accCnt   <= '0;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
    end else if (Start) begin
      outCount <= OutCount;
      bias     <= Bias;
      shift    <= Shift;
      accCnt   <= '0;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
    end else begin
      vld_p0  <= acc;
      last_p0 <= (accCnt + CNT_W'(1)) == outCount;
      if (acc) accCnt <= accCnt + CNT_W'(1);
    end
  end

  // Stage p0: quantized byte, one cycle after IOMapVld
  always_ff @(posedge clk_cal) begin
    if (acc) qByte_p0 <= sat8(roundShift(IOMap, bias, shift));
  end

  always_comb begin
    packData = packBuf;
    packData[{laneCnt, 3'b000} +: 8] = qByte_p0;
    packStrb = 4'h1;
    case (laneCnt)
      2'd0:    packStrb = 4'h1;
      2'd1:    packStrb = 4'h3;
      2'd2:    packStrb = 4'h7;
      default: packStrb = 4'hF;
    endcase
    // Lanes above the current one hold stale bytes from an earlier word.
    for (int i = 0; i < 4; i++) begin
      if (!packStrb[i]) packData[8*i +: 8] = 8'h00;
    end
    push = vld_p0 && ((laneCnt == 2'd3) || last_p0);
  end

  always_ff @(posedge clk_cal) begin
    if (vld_p0) packBuf <= packData;
    if (wrOk) begin
      memData[wrPtr] <= packData;
      memStrb[wrPtr] <= packStrb;
    end
  end

  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) begin
      laneCnt    <= '0;
      fifoCnt    <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      OOvf       <= 1'b0;
      lastPushed <= 1'b0;
      OWrAddr    <= '0;
    end else if (Start) begin
      laneCnt    <= '0;
      fifoCnt    <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      OOvf       <= 1'b0;
      lastPushed <= 1'b0;
      OWrAddr    <= BaseAddr;
    end else begin
      if (vld_p0) laneCnt <= push ? 2'd0 : laneCnt + 2'd1;
      if (wrOk) wrPtr <= wrPtr + PTR_W'(1);
      if (pop) begin
        rdPtr   <= rdPtr + PTR_W'(1);
        OWrAddr <= OWrAddr + ADDR_W'(1);
      end
      case ({wrOk, pop})
        2'b10:   fifoCnt <= fifoCnt + (PTR_W+1)'(1);
        2'b01:   fifoCnt <= fifoCnt - (PTR_W+1)'(1);
        default: fifoCnt <= fifoCnt;
      endcase
      if (push && full && !pop) OOvf <= 1'b1;
      if (push && last_p0) lastPushed <= 1'b1;
    end
  end

  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) state <= IDLE;
    else            state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (accCnt == outCount) stateNext = FLUSH;
      FLUSH:   if (lastPushed && (fifoCnt == '0)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = state;
    endcase
    if (Start) stateNext = RUN;
  end

  assign OWrEn   = (fifoCnt != '0);
  assign OWrData = OWrEn ? memData[rdPtr] : 32'h0;
  assign OWrStrb = OWrEn ? memStrb[rdPtr] : 4'h0;
  assign OBusy   = (state != IDLE);
  assign ODone   = (state == DONE);

endmodule

// File: tb/tb_u_ofmap_writer.sv
// Scoreboard bench for u_ofmap_writer: reference model packs quantized bytes into expected writes.
module tb_u_ofmap_writer;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  logic        clk_cal = 1'b0;
  logic        rst_cal_n = 1'b0;
  logic        Start = 1'b0;
  logic [9:0]  BaseAddr = '0;
  logic [15:0] OutCount = '0;
  logic [15:0] Bias = '0;
  logic [3:0]  Shift = '0;
  logic [15:0] IOMap = '0;
  logic        IOMapVld = 1'b0;
  logic        IWrReady = 1'b0;
  logic        OWrEn;
  logic [9:0]  OWrAddr;
  logic [31:0] OWrData;
  logic [3:0]  OWrStrb;
  logic        OBusy, ODone, OOvf;

  exp_t        expQ[$];
  logic [15:0] stimVals[$];
  int          checks = 0;
  int          errors = 0;
  int          doneCnt = 0;
  int          doneBase = 0;
  int          readyMode = 0;
  int          lowRun = 0;
  bit          expOvf = 0;
  bit          prevEn = 0, prevRdy = 0, prevDone = 0;
  logic [9:0]  prevAddr;
  logic [31:0] prevData;
  logic [3:0]  prevStrb;

  u_ofmap_writer dut (
    .clk_cal(clk_cal), .rst_cal_n(rst_cal_n), .Start(Start), .BaseAddr(BaseAddr),
    .OutCount(OutCount), .Bias(Bias), .Shift(Shift), .IOMap(IOMap), .IOMapVld(IOMapVld),
    .IWrReady(IWrReady), .OWrEn(OWrEn), .OWrAddr(OWrAddr), .OWrData(OWrData),
    .OWrStrb(OWrStrb), .OBusy(OBusy), .ODone(ODone), .OOvf(OOvf)
  );

  always #5 clk_cal = ~clk_cal;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int refQ(input logic [15:0] v, input logic [15:0] b, input int sh);
    int s;
    s = int'($signed(v)) + int'($signed(b));
    if (sh > 0) s = s + (1 << (sh - 1));
    s = s >>> sh;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`ifdef OFMAP_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Builds the expected write list from stimVals, then pulses Start with the configuration.
  task automatic startLayer(input logic [9:0] base, input int cnt, input logic [15:0] b,
                            input logic [3:0] sh, input bit stall);
    logic [31:0] word = '0;
    logic [3:0]  strb = '0;
    logic [7:0]  bt;
    int          lane = 0;
    int          widx = 0;
    exp_t        e;
    expOvf = 0;
    for (int i = 0; i < cnt; i++) begin
      bt = 8'(refQ(stimVals[i], b, int'(sh)));
      word = word | (32'(bt) << (8 * lane));
      strb = strb | 4'(1 << lane);
      lane++;
      if (lane == 4 || i == cnt - 1) begin
        if (stall && widx >= 4) expOvf = 1;
        else begin
          e.addr = 10'(int'(base) + widx);
          e.data = word;
          e.strb = strb;
          expQ.push_back(e);
        end
        widx++;
        word = '0;
        strb = '0;
        lane = 0;
      end
    end
    doneBase = doneCnt;
    @(posedge clk_cal); #1;
    Start = 1'b1; BaseAddr = base; OutCount = 16'(cnt); Bias = b; Shift = sh;
    @(posedge clk_cal); #1;
    Start = 1'b0;
  endtask

  task automatic feed(input int n, input int gapPct, input bit extra);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(99)) < gapPct) begin
        @(posedge clk_cal); #1;
        IOMapVld = 1'b0; IOMap = 16'($urandom);
      end
      @(posedge clk_cal); #1;
      IOMapVld = 1'b1; IOMap = stimVals[i];
    end
    if (extra) begin
      @(posedge clk_cal); #1;
      IOMapVld = 1'b1; IOMap = 16'($urandom);
    end
    @(posedge clk_cal); #1;
    IOMapVld = 1'b0;
  endtask

  task automatic finishLayer(input bit stall);
    bit got = 0;
    if (stall) begin
      repeat (6) @(posedge clk_cal);
      #1;
      chk("ovf_during_stall", OOvf, expOvf);
      chk("wren_during_stall", OWrEn, 1);
      repeat (3) @(posedge clk_cal);
      readyMode = 0;
    end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_cal);
      if (ODone) begin got = 1; break; end
    end
    if (!got) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk_cal);
    chk("done_pulses", doneCnt - doneBase, 1);
    chk("ovf_at_end", OOvf, expOvf);
    chk("writes_outstanding", expQ.size(), 0);
    chk("busy_after_done", OBusy, 0);
    expQ.delete();
  endtask

  task automatic chkIdleOutputs(input string tag);
    chk({tag, "_wren"}, OWrEn, 0);
    chk({tag, "_addr"}, OWrAddr, 0);
    chk({tag, "_data"}, OWrData, 0);
    chk({tag, "_strb"}, OWrStrb, 0);
    chk({tag, "_busy"}, OBusy, 0);
    chk({tag, "_done"}, ODone, 0);
    chk({tag, "_ovf"}, OOvf, 0);
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk_cal); #1;
        if (readyMode == 0) IWrReady = 1'b1;
        else if (readyMode == 2) IWrReady = 1'b0;
        else if (lowRun >= 2) begin IWrReady = 1'b1; lowRun = 0; end
        else begin
          IWrReady = 1'($urandom_range(1));
          lowRun = IWrReady ? 0 : lowRun + 1;
        end
      end
      forever begin
        @(negedge clk_cal);
        if (!rst_cal_n) begin prevEn = 0; prevDone = 0; continue; end
        if (prevEn && !prevRdy && OWrEn) begin
          chk("stall_addr_stable", OWrAddr, prevAddr);
          chk("stall_data_stable", OWrData, prevData);
          chk("stall_strb_stable", OWrStrb, prevStrb);
        end
        if (prevDone) chk("busy_falls_after_done", OBusy, 0);
        if (ODone) begin
          doneCnt++;
          chk("busy_on_done", OBusy, 1);
        end
        if (OWrEn && IWrReady) begin
          if (expQ.size() == 0) chk("write_expected", expQ.size(), 1);
          else begin
            exp_t e;
            e = expQ.pop_front();
            chk("wr_addr", OWrAddr, e.addr);
            chk("wr_data", OWrData, e.data);
            chk("wr_strb", OWrStrb, e.strb);
          end
        end
        prevEn = OWrEn; prevRdy = IWrReady; prevDone = ODone;
        prevAddr = OWrAddr; prevData = OWrData; prevStrb = OWrStrb;
      end
    join_none

    #12;
    chkIdleOutputs("reset");
    @(posedge clk_cal); #1;
    rst_cal_n = 1'b1;
    readyMode = 0;
    repeat (2) @(posedge clk_cal);

    stimVals = '{16'd1, 16'd2, 16'd3, 16'd4};
    startLayer(10'h010, 4, 16'h0000, 4'd0, 0);
    feed(4, 0, 0);
    finishLayer(0);

    stimVals = '{16'h0005};
    startLayer(10'h020, 1, 16'h0010, 4'd2, 0);
    feed(1, 0, 1);
    finishLayer(0);

    stimVals = '{16'h0200, 16'hFE00};
    startLayer(10'h030, 2, 16'h0000, 4'd0, 0);
    feed(2, 0, 1);
    finishLayer(0);

    stimVals = '{16'd10, 16'hFFF6, 16'd127, 16'd128, 16'hFF80, 16'hFF7F, 16'd0};
    startLayer(10'h040, 7, 16'h0000, 4'd0, 0);
    feed(7, 0, 1);
    finishLayer(0);

    stimVals.delete();
    for (int i = 0; i < 20; i++) stimVals.push_back(16'($urandom));
    readyMode = 2;
    startLayer(10'h050, 20, 16'h0003, 4'd3, 1);
    feed(20, 0, 0);
    finishLayer(1);

    // Abort: stalled layer with a full FIFO, overflow and a partial word, then restart.
    stimVals.delete();
    for (int i = 0; i < 24; i++) stimVals.push_back(16'($urandom));
    readyMode = 2;
    startLayer(10'h100, 24, 16'h0000, 4'd1, 1);
    feed(22, 0, 0);
    repeat (3) @(posedge clk_cal);
    #1;
    chk("abort_pre_ovf", OOvf, 1);
    expQ.delete();
    stimVals.delete();
    for (int i = 0; i < 12; i++) stimVals.push_back(16'($urandom));
    startLayer(10'h3FE, 12, 16'hFFF0, 4'd4, 0);
    chk("abort_ovf_cleared", OOvf, 0);
    chk("abort_fifo_empty", OWrEn, 0);
    chk("abort_addr_reload", OWrAddr, 10'h3FE);
    readyMode = 0;
    feed(12, 20, 1);
    finishLayer(0);

    readyMode = 1;
    for (int t = 0; t < 15; t++) begin
      int cnt;
      cnt = $urandom_range(24, 1);
      stimVals.delete();
      for (int i = 0; i < cnt; i++) stimVals.push_back(16'($urandom));
      startLayer(10'($urandom), cnt, 16'($urandom), 4'($urandom_range(15)), 0);
      feed(cnt, 30, 1);
      finishLayer(0);
    end

    // Reset while writes are pending.
    stimVals.delete();
    for (int i = 0; i < 12; i++) stimVals.push_back(16'($urandom));
    readyMode = 2;
    startLayer(10'h200, 12, 16'h0000, 4'd0, 1);
    feed(12, 0, 0);
    repeat (3) @(posedge clk_cal);
    #1;
    chk("pre_reset_wren", OWrEn, 1);
    rst_cal_n = 1'b0;
    #1;
    chkIdleOutputs("midreset");
    expQ.delete();
    @(posedge clk_cal); #1;
    rst_cal_n = 1'b1;
    readyMode = 0;

    stimVals = '{16'h0100, 16'hFF00, 16'h0040, 16'h0041, 16'h0001};
    startLayer(10'h2A0, 5, 16'h0001, 4'd1, 0);
    feed(5, 0, 1);
    finishLayer(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
